// File: rtl/div_pkg.sv
// Shared types and defaults for the iterative radix-2 divider.
package div_pkg;

    localparam int unsigned DEFAULT_DIV_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIXUP,
        DONE
    } div_state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial subtract, pick quotient bit.
module div_step
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_DIV_WIDTH
) (
    input  logic [WIDTH:0] rem_i,
    input  logic           dvd_msb_i,
    input  logic [WIDTH:0] dvs_i,
    output logic [WIDTH:0] rem_o,
    output logic           q_bit_o
);

    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] diff;

    // The extra top bit of diff acts as the borrow of the trial subtraction.
    always_comb begin
        shifted = {rem_i, dvd_msb_i};
        diff    = shifted - {1'b0, dvs_i};
        q_bit_o = ~diff[WIDTH+1];
        rem_o   = q_bit_o ? diff[WIDTH:0] : shifted[WIDTH:0];
    end

endmodule

// File: rtl/iterative_divider.sv
// Multi-cycle restoring divider with valid/ready handshakes on both sides.
// Define DIVIDER_SIGNED_EN for two's-complement operands; otherwise operands are unsigned.
module iterative_divider
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    div_state_e       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH:0]   rem_q, rem_d;
    logic [WIDTH:0]   dvs_q, dvs_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic             zero_q, zero_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             dbz_q, dbz_d;
`ifdef DIVIDER_SIGNED_EN
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;
`endif

    logic             dvd_neg, dvs_neg;
    logic [WIDTH:0]   dvd_ext, dvs_ext, dvd_mag, dvs_mag;
    logic [WIDTH:0]   step_rem;
    logic             step_bit;
    logic [WIDTH-1:0] fix_quo, fix_rem;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i     (rem_q),
        .dvd_msb_i (quo_q[WIDTH-1]),
        .dvs_i     (dvs_q),
        .rem_o     (step_rem),
        .q_bit_o   (step_bit)
    );

    // Operand magnitudes carry one extra bit so the most-negative value negates cleanly.
    always_comb begin
`ifdef DIVIDER_SIGNED_EN
        dvd_neg = dividend[WIDTH-1];
        dvs_neg = divisor[WIDTH-1];
`else
        dvd_neg = 1'b0;
        dvs_neg = 1'b0;
`endif
        dvd_ext = {dvd_neg, dividend};
        dvs_ext = {dvs_neg, divisor};
        dvd_mag = dvd_neg ? -dvd_ext : dvd_ext;
        dvs_mag = dvs_neg ? -dvs_ext : dvs_ext;
    end

    // Result selection; on a zero divisor quo_q still holds the dividend magnitude.
    always_comb begin
        fix_quo = zero_q ? '1 : quo_q;
        fix_rem = zero_q ? quo_q : rem_q[WIDTH-1:0];
`ifdef DIVIDER_SIGNED_EN
        if (qneg_q && !zero_q) fix_quo = -quo_q;
        if (rneg_q)            fix_rem = -fix_rem;
`endif
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        dvs_d       = dvs_q;
        quo_d       = quo_q;
        zero_d      = zero_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
`ifdef DIVIDER_SIGNED_EN
        qneg_d      = qneg_q;
        rneg_d      = rneg_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    {rem_d, quo_d} = {WIDTH'(0), dvd_mag};
                    dvs_d          = dvs_mag;
                    zero_d         = (divisor == '0);
                    cnt_d          = '0;
                    in_ready_d     = 1'b0;
`ifdef DIVIDER_SIGNED_EN
                    qneg_d         = dvd_neg ^ dvs_neg;
                    rneg_d         = dvd_neg;
`endif
                    state_d        = (divisor == '0) ? FIXUP : CALC;
                end
            end
            CALC: begin
                rem_d = step_rem;
                quo_d = {quo_q[WIDTH-2:0], step_bit};
                if (cnt_q == CW'(WIDTH - 1)) begin
                    cnt_d   = '0;
                    state_d = FIXUP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            FIXUP: begin
                quotient_d  = fix_quo;
                remainder_d = fix_rem;
                dbz_d       = zero_q;
                out_valid_d = 1'b1;
                state_d     = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            dvs_q       <= '0;
            quo_q       <= '0;
            zero_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
`ifdef DIVIDER_SIGNED_EN
            qneg_q      <= 1'b0;
            rneg_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            dvs_q       <= dvs_d;
            quo_q       <= quo_d;
            zero_q      <= zero_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
`ifdef DIVIDER_SIGNED_EN
            qneg_q      <= qneg_d;
            rneg_q      <= rneg_d;
`endif
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_iterative_divider.sv
// Scoreboard bench for iterative_divider at WIDTH=16; honours DIVIDER_SIGNED_EN like the RTL.
module tb_iterative_divider;

    localparam int W = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  dividend;
    logic [W-1:0]  divisor;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  quotient;
    logic [W-1:0]  remainder;
    logic          div_by_zero;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
        int           lat;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    iterative_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
`ifdef DIVIDER_SIGNED_EN
        int sa;
        int sbv;
`endif
        e.dbz = (b == '0);
        e.lat = (b == '0) ? 2 : W + 2;
        if (b == '0) begin
            e.q = '1;
            e.r = a;
        end else begin
`ifdef DIVIDER_SIGNED_EN
            sa  = int'($signed(a));
            sbv = int'($signed(b));
            e.q = W'(sa / sbv);
            e.r = W'(sa % sbv);
`else
            e.q = a / b;
            e.r = a % b;
`endif
        end
        return e;
    endfunction

    // Waits for in_ready, then presents one operand pair for a single cycle.
    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
        int guard = 0;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL start_timeout: in_ready=%b want 1", in_ready);
        end
        dividend = a;
        divisor  = b;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Counts cycles from the transfer cycle until out_valid, bounded.
    task automatic wait_result(inout int lat);
        while (!out_valid && lat < 64) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        checks++; if (in_ready !== 1'b1)     begin errors++; $display("FAIL reset in_ready: got %b want 1", in_ready); end
        checks++; if (out_valid !== 1'b0)    begin errors++; $display("FAIL reset out_valid: got %b want 0", out_valid); end
        checks++; if (quotient !== '0)       begin errors++; $display("FAIL reset quotient: got %h want 0", quotient); end
        checks++; if (remainder !== '0)      begin errors++; $display("FAIL reset remainder: got %h want 0", remainder); end
        checks++; if (div_by_zero !== 1'b0)  begin errors++; $display("FAIL reset div_by_zero: got %b want 0", div_by_zero); end
    endtask

    task automatic test_basic();
        logic [W-1:0] ta [5] = '{16'd100, 16'd50000, 16'd7, 16'hFFFF, 16'd12345};
        logic [W-1:0] tb [5] = '{16'd7,   16'd3,     16'd100, 16'd1,  16'h0100};
        exp_t e;
        int   lat;
        for (int i = 0; i < 5; i++) begin
            sb.push_back(model(ta[i], tb[i]));
            start_op(ta[i], tb[i]);
            lat = 1;
            wait_result(lat);
            e = sb.pop_front();
            checks++; if (lat != e.lat)          begin errors++; $display("FAIL basic%0d latency: got %0d want %0d", i, lat, e.lat); end
            checks++; if (quotient !== e.q)      begin errors++; $display("FAIL basic%0d quotient: got %h want %h", i, quotient, e.q); end
            checks++; if (remainder !== e.r)     begin errors++; $display("FAIL basic%0d remainder: got %h want %h", i, remainder, e.r); end
            checks++; if (div_by_zero !== e.dbz) begin errors++; $display("FAIL basic%0d div_by_zero: got %b want %b", i, div_by_zero, e.dbz); end
            consume();
        end
    endtask

    task automatic test_sign_cases();
        logic [W-1:0] ta [2] = '{16'hFF9C, 16'h8000};
        logic [W-1:0] tb [2] = '{16'd7,    16'hFFFF};
        exp_t e;
        int   lat;
        for (int i = 0; i < 2; i++) begin
`ifdef DIVIDER_SIGNED_EN
            e.q = (i == 0) ? 16'hFFF2 : 16'h8000;
            e.r = (i == 0) ? 16'hFFFE : 16'h0000;
`else
            e.q = (i == 0) ? 16'd0      : 16'h0000;
            e.r = (i == 0) ? 16'hFF9C % 16'd7 : 16'h8000;
            if (i == 0) e.q = 16'hFF9C / 16'd7;
`endif
            e.dbz = 1'b0;
            e.lat = W + 2;
            sb.push_back(e);
            start_op(ta[i], tb[i]);
            lat = 1;
            wait_result(lat);
            e = sb.pop_front();
            checks++; if (lat != e.lat)          begin errors++; $display("FAIL sign%0d latency: got %0d want %0d", i, lat, e.lat); end
            checks++; if (quotient !== e.q)      begin errors++; $display("FAIL sign%0d quotient: got %h want %h", i, quotient, e.q); end
            checks++; if (remainder !== e.r)     begin errors++; $display("FAIL sign%0d remainder: got %h want %h", i, remainder, e.r); end
            checks++; if (div_by_zero !== e.dbz) begin errors++; $display("FAIL sign%0d div_by_zero: got %b want %b", i, div_by_zero, e.dbz); end
            consume();
        end
    endtask

    task automatic test_div_zero();
        exp_t e;
        int   lat;
        e.q = 16'hFFFF; e.r = 16'd1234; e.dbz = 1'b1; e.lat = 2;
        sb.push_back(e);
        start_op(16'd1234, 16'd0);
        lat = 1;
        wait_result(lat);
        e = sb.pop_front();
        checks++; if (lat != e.lat)          begin errors++; $display("FAIL dbz latency: got %0d want %0d", lat, e.lat); end
        checks++; if (quotient !== e.q)      begin errors++; $display("FAIL dbz quotient: got %h want %h", quotient, e.q); end
        checks++; if (remainder !== e.r)     begin errors++; $display("FAIL dbz remainder: got %h want %h", remainder, e.r); end
        checks++; if (div_by_zero !== e.dbz) begin errors++; $display("FAIL dbz div_by_zero: got %b want %b", div_by_zero, e.dbz); end
        consume();
    endtask

    task automatic test_backpressure();
        exp_t e;
        int   lat;
        sb.push_back(model(16'd1000, 16'd7));
        start_op(16'd1000, 16'd7);
        lat = 1;
        for (int k = 0; k < 6; k++) begin
            dividend = 16'd5;
            divisor  = 16'd1;
            in_valid = k[0];
            @(negedge clk);
            lat++;
        end
        in_valid = 1'b0;
        wait_result(lat);
        e = sb.pop_front();
        checks++; if (lat != e.lat) begin errors++; $display("FAIL bp latency: got %0d want %0d", lat, e.lat); end
        for (int k = 0; k < 5; k++) begin
            checks++; if (out_valid !== 1'b1)    begin errors++; $display("FAIL bp%0d out_valid: got %b want 1", k, out_valid); end
            checks++; if (in_ready !== 1'b0)     begin errors++; $display("FAIL bp%0d in_ready: got %b want 0", k, in_ready); end
            checks++; if (quotient !== e.q)      begin errors++; $display("FAIL bp%0d quotient: got %h want %h", k, quotient, e.q); end
            checks++; if (remainder !== e.r)     begin errors++; $display("FAIL bp%0d remainder: got %h want %h", k, remainder, e.r); end
            checks++; if (div_by_zero !== e.dbz) begin errors++; $display("FAIL bp%0d div_by_zero: got %b want %b", k, div_by_zero, e.dbz); end
            @(negedge clk);
        end
        consume();
        checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL bp_exit in_ready: got %b want 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_exit out_valid: got %b want 0", out_valid); end
        repeat (3) @(negedge clk);
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL bp_idle: out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset_mid_calc();
        exp_t e;
        int   lat;
        sb.push_back(model(16'd1000, 16'd3));
        start_op(16'd1000, 16'd3);
        repeat (7) @(negedge clk);
        rst = 1'b1;
        #1;
        void'(sb.pop_back());
        checks++; if (out_valid !== 1'b0)   begin errors++; $display("FAIL midrst out_valid: got %b want 0", out_valid); end
        checks++; if (in_ready !== 1'b1)    begin errors++; $display("FAIL midrst in_ready: got %b want 1", in_ready); end
        checks++; if (quotient !== '0)      begin errors++; $display("FAIL midrst quotient: got %h want 0", quotient); end
        checks++; if (remainder !== '0)     begin errors++; $display("FAIL midrst remainder: got %h want 0", remainder); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        e.q = 16'd10; e.r = 16'd0; e.dbz = 1'b0; e.lat = W + 2;
        sb.push_back(e);
        start_op(16'd50, 16'd5);
        lat = 1;
        wait_result(lat);
        e = sb.pop_front();
        checks++; if (lat != e.lat)      begin errors++; $display("FAIL post_rst latency: got %0d want %0d", lat, e.lat); end
        checks++; if (quotient !== e.q)  begin errors++; $display("FAIL post_rst quotient: got %h want %h", quotient, e.q); end
        checks++; if (remainder !== e.r) begin errors++; $display("FAIL post_rst remainder: got %h want %h", remainder, e.r); end
        consume();
    endtask

    task automatic test_back_to_back();
        exp_t         e;
        int           lat;
        logic [W-1:0] a;
        logic [W-1:0] b;
        for (int i = 0; i < 12; i++) begin
            a = W'($urandom);
            b = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 2)) : W'($urandom);
            if (i == 0) b = 16'hFFFF;
            if (i == 1) a = 16'h8000;
            sb.push_back(model(a, b));
            start_op(a, b);
            lat = 1;
            wait_result(lat);
            e = sb.pop_front();
            checks++; if (lat != e.lat)          begin errors++; $display("FAIL b2b%0d latency: got %0d want %0d (a=%h b=%h)", i, lat, e.lat, a, b); end
            checks++; if (quotient !== e.q)      begin errors++; $display("FAIL b2b%0d quotient: got %h want %h (a=%h b=%h)", i, quotient, e.q, a, b); end
            checks++; if (remainder !== e.r)     begin errors++; $display("FAIL b2b%0d remainder: got %h want %h (a=%h b=%h)", i, remainder, e.r, a, b); end
            checks++; if (div_by_zero !== e.dbz) begin errors++; $display("FAIL b2b%0d div_by_zero: got %b want %b", i, div_by_zero, e.dbz); end
            consume();
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b%0d in_ready: got %b want 1", i, in_ready); end
        end
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = '0;
        divisor   = '0;
        repeat (3) @(negedge clk);
        test_reset();
        rst = 1'b0;
        @(negedge clk);
        test_basic();
        test_sign_cases();
        test_div_zero();
        test_backpressure();
        test_reset_mid_calc();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
